load_align_unit: RTL and testbench

LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

---
 rtl/load_align_unit.sv | 176 +++++++++++++++++
 tb/tb_load_align_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
// Load alignment unit: issues word-aligned memory reads for MIPS-style loads,
// extracts and extends the addressed byte/halfword, and aborts on a memory timeout.
module load_align_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_req,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ld_data,
  output logic        ld_done,
  output logic        busy,
  output logic        adel,
  output logic        bus_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state, nxt_state;
  logic [CW-1:0]  cnt, nxt_cnt;
  logic [5:0]     op_q, nxt_op;
  logic [1:0]     off_q, nxt_off;
  logic [31:0]    nxt_mem_addr, nxt_data;
  logic           nxt_mem_req, nxt_busy, nxt_done, nxt_adel, nxt_berr;

  logic           is_load_c;
  logic           aligned_c;
  logic [7:0]     byte_c;
  logic [15:0]    half_c;
  logic [31:0]    ext_c;

  // Request decode: which ops are loads and whether the address suits the width
  always_comb begin
    is_load_c = 1'b0;
    aligned_c = 1'b0;
    case (op)
      OP_LB, OP_LBU: begin
        is_load_c = 1'b1;
        aligned_c = 1'b1;
      end
      OP_LH, OP_LHU: begin
        is_load_c = 1'b1;
        aligned_c = (addr[0] == 1'b0);
      end
      OP_LW: begin
        is_load_c = 1'b1;
        aligned_c = (addr[1:0] == 2'b00);
      end
      default: begin
        is_load_c = 1'b0;
        aligned_c = 1'b0;
      end
    endcase
  end

  // Lane select and sign/zero extension of the returned word
  always_comb begin
    byte_c = mem_rdata[7:0];
    case (off_q)
      2'd0:    byte_c = mem_rdata[7:0];
      2'd1:    byte_c = mem_rdata[15:8];
      2'd2:    byte_c = mem_rdata[23:16];
      default: byte_c = mem_rdata[31:24];
    endcase
    half_c = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q)
      OP_LB:   ext_c = {{24{byte_c[7]}}, byte_c};
      OP_LBU:  ext_c = {24'h0, byte_c};
      OP_LH:   ext_c = {{16{half_c[15]}}, half_c};
      OP_LHU:  ext_c = {16'h0, half_c};
      default: ext_c = mem_rdata;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    nxt_state    = state;
    nxt_cnt      = cnt;
    nxt_op       = op_q;
    nxt_off      = off_q;
    nxt_mem_addr = mem_addr;
    nxt_data     = ld_data;
    nxt_mem_req  = 1'b0;
    nxt_busy     = 1'b0;
    nxt_done     = 1'b0;
    nxt_adel     = 1'b0;
    nxt_berr     = 1'b0;
    case (state)
      S_IDLE: begin
        if (ld_req && is_load_c) begin
          if (aligned_c) begin
            nxt_state    = S_WAIT;
            nxt_cnt      = '0;
            nxt_op       = op;
            nxt_off      = addr[1:0];
            nxt_mem_addr = {addr[31:2], 2'b00};
            nxt_mem_req  = 1'b1;
            nxt_busy     = 1'b1;
          end else begin
            nxt_adel = 1'b1;
            nxt_data = '0;
          end
        end
      end
      S_WAIT: begin
        // An ack in the final allowed cycle still completes normally
        if (mem_ack) begin
          nxt_state = S_DONE;
          nxt_data  = ext_c;
          nxt_done  = 1'b1;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          nxt_state = S_IDLE;
          nxt_cnt   = cnt + CW'(1);
          nxt_berr  = 1'b1;
          nxt_data  = '0;
        end else begin
          nxt_cnt     = cnt + CW'(1);
          nxt_mem_req = 1'b1;
          nxt_busy    = 1'b1;
        end
      end
      S_DONE: begin
        nxt_state = S_IDLE;
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_q     <= '0;
      off_q    <= '0;
      mem_addr <= '0;
      ld_data  <= '0;
      mem_req  <= 1'b0;
      busy     <= 1'b0;
      ld_done  <= 1'b0;
      adel     <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      op_q     <= nxt_op;
      off_q    <= nxt_off;
      mem_addr <= nxt_mem_addr;
      ld_data  <= nxt_data;
      mem_req  <= nxt_mem_req;
      busy     <= nxt_busy;
      ld_done  <= nxt_done;
      adel     <= nxt_adel;
      bus_err  <= nxt_berr;
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: vector table of single loads plus
// hand-written timeout, reset, non-load and back-to-back sequences.
module tb_load_align_unit;

  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] SW  = 6'b101011;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_req;
  logic [5:0]  op;
  logic [31:0] addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] ld_data;
  logic        ld_done;
  logic        busy;
  logic        adel;
  logic        bus_err;

  int checks = 0;
  int failures = 0;

  load_align_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .ld_req(ld_req), .op(op), .addr(addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .ld_data(ld_data), .ld_done(ld_done),
    .busy(busy), .adel(adel), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] rdata;
    int          delay;
    logic        exp_adel;
    logic [31:0] exp_maddr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One load through the unit; inputs change and outputs are sampled on negedges
  task automatic do_load(input vec_t v);
    @(negedge clk);
    ld_req = 1'b1; op = v.op; addr = v.addr;
    @(negedge clk);
    ld_req = 1'b0;
    if (v.exp_adel) begin
      chk("adel_pulse", 32'(adel), 32'd1);
      chk("adel_no_req", 32'(mem_req), 32'd0);
      chk("adel_data", ld_data, 32'd0);
      @(negedge clk);
      chk("adel_one_cycle", 32'(adel), 32'd0);
      chk("adel_no_req2", 32'(mem_req), 32'd0);
    end else begin
      chk("wait_req", 32'(mem_req), 32'd1);
      chk("wait_busy", 32'(busy), 32'd1);
      chk("mem_addr", mem_addr, v.exp_maddr);
      for (int i = 0; i < v.delay; i++) begin
        @(negedge clk);
        chk("wait_req_held", 32'(mem_req), 32'd1);
        chk("mem_addr_stable", mem_addr, v.exp_maddr);
      end
      mem_ack = 1'b1; mem_rdata = v.rdata;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 32'h0;
      chk("done_pulse", 32'(ld_done), 32'd1);
      chk("ld_data", ld_data, v.exp_data);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_req", 32'(mem_req), 32'd0);
      chk("done_no_berr", 32'(bus_err), 32'd0);
      @(negedge clk);
      chk("done_one_cycle", 32'(ld_done), 32'd0);
      chk("ld_data_hold", ld_data, v.exp_data);
    end
  endtask

  initial begin
    vec_t v;
    int   req_cycles;
    vecs[0]  = '{LB,  32'h0000_1003, 32'h80FF_1234, 0,  1'b0, 32'h0000_1000, 32'hFFFF_FF80};
    vecs[1]  = '{LHU, 32'h0000_2002, 32'h9ABC_5678, 3,  1'b0, 32'h0000_2000, 32'h0000_9ABC};
    vecs[2]  = '{LH,  32'h0000_2002, 32'h9ABC_5678, 3,  1'b0, 32'h0000_2000, 32'hFFFF_9ABC};
    vecs[3]  = '{LW,  32'h0000_3002, 32'h0,         0,  1'b1, 32'h0,         32'h0};
    vecs[4]  = '{LW,  32'h0000_4000, 32'hDEAD_BEEF, 1,  1'b0, 32'h0000_4000, 32'hDEAD_BEEF};
    vecs[5]  = '{LH,  32'h0000_3001, 32'h0,         0,  1'b1, 32'h0,         32'h0};
    vecs[6]  = '{LBU, 32'h0000_5001, 32'h12AB_34CD, 0,  1'b0, 32'h0000_5000, 32'h0000_0034};
    vecs[7]  = '{LB,  32'h0000_5002, 32'h12AB_34CD, 2,  1'b0, 32'h0000_5000, 32'hFFFF_FFAB};
    vecs[8]  = '{LH,  32'h0000_6000, 32'h0000_8001, 0,  1'b0, 32'h0000_6000, 32'hFFFF_8001};
    vecs[9]  = '{LHU, 32'h0000_6003, 32'h0,         0,  1'b1, 32'h0,         32'h0};
    vecs[10] = '{LHU, 32'h0000_6000, 32'h1234_7FFE, 0,  1'b0, 32'h0000_6000, 32'h0000_7FFE};
    vecs[11] = '{LW,  32'h0000_7004, 32'h0BAD_F00D, 15, 1'b0, 32'h0000_7004, 32'h0BAD_F00D};

    rst = 1'b1; ld_req = 1'b0; op = 6'h0; addr = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ld_done", 32'(ld_done), 32'd0);
    chk("rst_adel", 32'(adel), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);

    for (int i = 0; i < 12; i++) do_load(vecs[i]);

    // Non-load op: nothing happens, ld_data keeps the previous result
    @(negedge clk);
    ld_req = 1'b1; op = SW; addr = 32'h0000_0003;
    @(negedge clk);
    ld_req = 1'b0;
    chk("nonload_req", 32'(mem_req), 32'd0);
    chk("nonload_adel", 32'(adel), 32'd0);
    chk("nonload_busy", 32'(busy), 32'd0);
    chk("nonload_data", ld_data, 32'h0BAD_F00D);

    // Timeout: mem_req held exactly 16 cycles, then one bus_err, late ack ignored
    @(negedge clk);
    ld_req = 1'b1; op = LW; addr = 32'h0000_8000;
    @(negedge clk);
    ld_req = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!mem_req) break;
      req_cycles++;
      @(negedge clk);
    end
    chk("timeout_req_cycles", 32'(req_cycles), 32'd16);
    chk("timeout_bus_err", 32'(bus_err), 32'd1);
    chk("timeout_data", ld_data, 32'd0);
    chk("timeout_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("bus_err_one_cycle", 32'(bus_err), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stale_ack_done", 32'(ld_done), 32'd0);
    chk("stale_ack_data", ld_data, 32'd0);
    chk("stale_ack_req", 32'(mem_req), 32'd0);

    // Reset in WAIT: abandoned request never completes
    v = '{LW, 32'h0000_9000, 32'h1357_2468, 0, 1'b0, 32'h0000_9000, 32'h1357_2468};
    do_load(v);
    @(negedge clk);
    ld_req = 1'b1; op = LW; addr = 32'h0000_9100;
    @(negedge clk);
    ld_req = 1'b0;
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_data", ld_data, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("midrst_no_done", 32'(ld_done), 32'd0);
    chk("midrst_data2", ld_data, 32'd0);
    v = '{LBU, 32'h0000_0000, 32'h0000_00F0, 0, 1'b0, 32'h0000_0000, 32'h0000_00F0};
    do_load(v);

    // Back-to-back with ld_req held: second accepted only after DONE
    @(negedge clk);
    ld_req = 1'b1; op = LW; addr = 32'h0000_A000;
    @(negedge clk);
    chk("b2b_first_req", 32'(mem_req), 32'd1);
    chk("b2b_first_addr", mem_addr, 32'h0000_A000);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_ack = 1'b0;
    op = LHU; addr = 32'h0000_A006;
    chk("b2b_first_done", 32'(ld_done), 32'd1);
    chk("b2b_first_data", ld_data, 32'h1111_2222);
    @(negedge clk);
    chk("b2b_done_ignored", 32'(mem_req), 32'd0);
    chk("b2b_idle_done", 32'(ld_done), 32'd0);
    @(negedge clk);
    ld_req = 1'b0;
    chk("b2b_second_req", 32'(mem_req), 32'd1);
    chk("b2b_second_addr", mem_addr, 32'h0000_A004);
    mem_ack = 1'b1; mem_rdata = 32'hBEEF_0000;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("b2b_second_done", 32'(ld_done), 32'd1);
    chk("b2b_second_data", ld_data, 32'h0000_BEEF);
    @(negedge clk);
    chk("b2b_end_req", 32'(mem_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
